// File: rtl/mem_arb_pkg.sv
// Shared types and line geometry for the I/D memory-port arbiter.
// The line size is fixed here so every file derives the same beat and offset widths.
package mem_arb_pkg;

  localparam int LINE_WORDS = 4;
  localparam int BEAT_W     = $clog2(LINE_WORDS);
  localparam int OFFSET_W   = BEAT_W + 2;

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_e;
  typedef enum logic {GNT_I, GNT_D} grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker for the I/D requesters. It is purely combinational.
// Under contention it favours the side that did not win last; the caller holds last_gnt.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_e last_gnt,
  output grant_e gnt,
  output logic   any
);

  always_comb begin
    gnt = GNT_I;
    if (req_i && req_d) begin
      gnt = (last_gnt == GNT_D) ? GNT_I : GNT_D;
    end else if (req_d) begin
      gnt = GNT_D;
    end
  end

  assign any = req_i | req_d;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between ICACHE refill and DCACHE refill/writeback, granting a whole line burst at a time.
// A line takes LINE_WORDS+2 cycles with mem_ready high; mem_ready low stalls the current beat with all outputs held.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [BEAT_W-1:0] d_wbeat,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

  state_e            state;
  grant_e            gnt_q;
  grant_e            last_gnt;
  grant_e            pick;
  logic              any_req;
  logic              we_q;
  logic [ADDR_W-1:0] base_q;
  logic [BEAT_W-1:0] beat;
  logic              in_burst;
  logic              last_beat;

  rr_arb2 u_rr (
    .req_i    (i_req),
    .req_d    (d_req),
    .last_gnt (last_gnt),
    .gnt      (pick),
    .any      (any_req)
  );

  // Memory-side outputs decode registered state only, so they hold steady through stalls.
  assign in_burst  = (state == BURST);
  assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));
  assign mem_valid = in_burst;
  assign mem_we    = in_burst && we_q;
  assign mem_addr  = in_burst ? (base_q + ADDR_W'({beat, 2'b00})) : '0;
  assign mem_wdata = mem_we ? d_wdata : '0;
  assign d_wbeat   = mem_we ? beat : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= GNT_I;
      last_gnt <= GNT_D;
      we_q     <= 1'b0;
      base_q   <= '0;
      beat     <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q    <= pick;
            last_gnt <= pick;
            we_q     <= (pick == GNT_D) && d_we;
            base_q   <= ((pick == GNT_I) ? i_addr : d_addr) & LINE_MASK;
            beat     <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (mem_ready) begin
            beat <= beat + BEAT_W'(1);
            if (!we_q) begin
              if (gnt_q == GNT_I) begin
                i_rdata  <= mem_rdata;
                i_rvalid <= 1'b1;
              end else begin
                d_rdata  <= mem_rdata;
                d_rvalid <= 1'b1;
              end
            end
            if (last_beat) begin
              state  <= DONE;
              i_done <= (gnt_q == GNT_I);
              d_done <= (gnt_q == GNT_D);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one backing-memory port between the instruction-cache refill path (read-only) and the data-cache refill/writeback path (read/write) of the CPU top.
- Each transaction is a line burst of LINE_WORDS words.
- Each requester is granted exclusively for a whole burst. Contention is resolved round-robin.
- Sits between the ICACHE/DCACHE miss logic and the memory model in CPU_TOP.

Parameters:
- LINE_WORDS, 4, words per cache line (power of two, ≥2).
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  ICACHE line-read request; held until i_done.
- i_addr  in  ADDR_W  ICACHE line address; stable while i_req is high.
- i_rvalid  out  1  one read beat valid on i_rdata.
- i_rdata  out  DATA_W  read word.
- i_done  out  1  one-cycle pulse marking the end of the I burst.
- d_req  in  1  DCACHE request; held until d_done.
- d_we  in  1  1 = line write (writeback), 0 = line read; stable with d_req.
- d_addr  in  ADDR_W  DCACHE line address.
- d_wbeat  out  $clog2(LINE_WORDS)  beat index whose write data is required now.
- d_wdata  in  DATA_W  write word for beat d_wbeat; combinational from the DCACHE line buffer.
- d_rvalid  out  1  one read beat valid on d_rdata.
- d_rdata  out  DATA_W  read word.
- d_done  out  1  one-cycle pulse marking the end of the D burst.
- mem_valid  out  1  beat request to memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word address of the beat.
- mem_wdata  out  DATA_W  write word.
- mem_ready  in  1  memory accepts/completes the beat this cycle; mem_rdata is valid when mem_we=0.
- mem_rdata  in  DATA_W  read word.

Behaviour:
- FSM states: IDLE, BURST, DONE.
- Reset values: state=IDLE, beat=0, last_gnt=D. Every output is 0, including mem_valid, mem_we, mem_addr, mem_wdata, both rvalid, both done, and d_wbeat.
- **IDLE:**
  - Only one requester has req=1 → grant it.
  - Both have req=1 → grant the one that is not last_gnt. The first contended grant after reset therefore goes to I.
  - Grant, we (0 for I), and the line-aligned address are registered: the low log2(LINE_WORDS)+2 address bits are forced to 0.
  - last_gnt is updated, and the FSM moves to BURST in the same edge.
- **BURST:**
  - mem_valid=1.
  - mem_addr = base + beat*4.
  - mem_we = registered we.
  - mem_wdata = d_wdata, with d_wbeat = beat (D write only; otherwise d_wbeat=0).
  - A handshake is mem_valid & mem_ready. On each handshake, beat increments.
  - For reads, mem_rdata is registered to the granted requester's rdata, and its rvalid is asserted on the next cycle. The non-granted requester's rvalid stays 0.
  - mem_ready may stall any number of cycles. Outputs stay stable while stalled.
  - The handshake on beat LINE_WORDS-1 → DONE, and beat wraps to 0.
- **DONE (one cycle):**
  - The granted requester's done=1. For reads this coincides with the last rvalid.
  - mem_valid=0. Next state is IDLE.
  - The requester must drop req on the edge at which it sees done. IDLE re-samples on the following cycle, so there is no stale re-grant.
- Latency with mem_ready tied high: req seen in IDLE at cycle 0 → mem_valid cycles 1..LINE_WORDS → done at cycle LINE_WORDS+1 → IDLE at LINE_WORDS+2. For LINE_WORDS=4, a line takes 6 cycles.
- A req that rises during another requester's BURST waits; it is not dropped.
- A req that falls while not granted has no effect.
- Address changes while req is high are undefined; the arbiter uses the registered copy.
- rst asserted mid-burst → on the next edge: IDLE, mem_valid=0, beat=0, last_gnt=D, no done pulse. The memory transaction is abandoned.
- mem_ready while mem_valid=0 is ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BURST, DONE};
  - grant enum {GNT_I, GNT_D};
  - localparam BEAT_W = $clog2(LINE_WORDS);
  - localparam OFFSET_W = BEAT_W + 2.
- Sub-module rr_arb2: a 2-way round-robin picker. Inputs req_i, req_d, last_gnt. Outputs gnt and any. Purely combinational; last_gnt is held in mem_arbiter.

Test Plan:
1. I-only read, LINE_WORDS=4, mem_ready=1, i_addr=0x0000_1234, memory returns 0xA0..0xA3 → mem_addr 0x1230, 0x1234, 0x1238, 0x123C on cycles 1..4; i_rvalid on cycles 2..5 with data 0xA0..0xA3; i_done on cycle 5 only; d_rvalid=0 throughout.
2. D write burst, d_addr=0x2000, line buffer {11,22,33,44} indexed by d_wbeat → mem_we=1 with mem_wdata 11, 22, 33, 44 at mem_addr 0x2000..0x200C; d_done one pulse; no rvalid.
3. i_req and d_req both rise in the same cycle after reset → I granted first; D is granted in the first IDLE after i_done. Repeat with both held continuously → grants alternate I, D, I, D.
4. mem_ready toggles 1,0,0,1,1,0,1 during a D read → exactly 4 handshakes; mem_addr holds during stalls; d_rvalid count is 4; d_done follows the 4th handshake by one cycle.
5. rst pulsed after the 2nd beat of an I read → mem_valid=0 and no i_done on the next cycle; with both req then high, the next grant goes to I (last_gnt reset to D).
6. Back-to-back: i_req dropped on i_done and re-raised one cycle later → new burst starts; no duplicate grant of the old request.
